cpu7_ifu_imem_bridge: RTL

//  - Fetch-side bus bridge between the IFU fetch datapath and the SRAM-like instruction bus.
//  - Forwards fetch requests and counts outstanding requests.
//  - Drops responses that belong to cancelled requests after a branch, exception or ertn redirect.
//  - Raises fetch exceptions: misaligned PC (ADEF) and bus error.
//  - Drives the fetch-stage inst_* response group consumed by the fetch datapath.

---
 rtl/cpu7_ifu_imem_bridge.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cpu7_ifu_imem_bridge.sv
// IFU fetch-side bridge to the SRAM-like instruction bus: request issue, redirect discard, ADEF and bus-error reporting.
// Define CPU7_IFU_IMEM_RESP_BUF_EN to register the inst_* response group (+1 cycle on bus responses).
module cpu7_ifu_imem_bridge #(
   parameter int unsigned GRLEN       = 32,
   parameter int unsigned MAX_OUTST   = 2,
   parameter int unsigned CNT_W       = 3,
   parameter logic [5:0]  ADEF_CODE   = 6'h08,
   parameter logic [5:0]  BUSERR_CODE = 6'h0a
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inst_req,
   input  logic [31:0]      inst_addr,
   input  logic             inst_cancel,
   output logic             inst_addr_ok,
   output logic             inst_valid_f,
   output logic [GRLEN-1:0] inst_rdata_f,
   output logic             inst_ex,
   output logic [5:0]       inst_exccode,
   output logic [1:0]       inst_count,
   output logic             inst_uncache,
   output logic             bus_req,
   output logic [31:0]      bus_addr,
   input  logic             bus_addr_ok,
   input  logic             bus_data_ok,
   input  logic [31:0]      bus_rdata,
   input  logic             bus_err,
   input  logic             bus_uncache
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0] outst_q, outst_d;
   logic [CNT_W-1:0] disc_q, disc_d;
   logic             adef_pend_q, adef_pend_d;

   logic             mis, issue, adef_acc, acc, beat, bus_valid;

   // response candidate before optional buffering
   logic             resp_v, resp_ex, resp_unc;
   logic [GRLEN-1:0] resp_rd;
   logic [5:0]       resp_code;

   // response as presented to the fetch datapath
   logic             out_v, out_ex, out_unc;
   logic [GRLEN-1:0] out_rd;
   logic [5:0]       out_code;

   // counter state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         outst_q     <= '0;
         disc_q      <= '0;
         adef_pend_q <= 1'b0;
      end else begin
         outst_q     <= outst_d;
         disc_q      <= disc_d;
         adef_pend_q <= adef_pend_d;
      end
   end

   // issue, ADEF acceptance and counter next-state
   always_comb begin
      mis       = (inst_addr[1:0] != 2'b00);
      issue     = inst_req & ~inst_cancel & ~mis & ~adef_pend_q & (outst_q < MAX_CNT);
      adef_acc  = inst_req & ~inst_cancel & mis & ~adef_pend_q & (outst_q == '0);
      acc       = issue & bus_addr_ok;
      // a data_ok with nothing outstanding is ignored
      beat      = bus_data_ok & (outst_q != '0);
      bus_valid = beat & (disc_q == '0) & ~inst_cancel;

      outst_d     = outst_q + CNT_W'(acc) - CNT_W'(beat);
      adef_pend_d = adef_acc;
      disc_d      = disc_q;
      if (inst_cancel) begin
         disc_d = outst_q - CNT_W'(beat);
      end else if (beat && (disc_q != '0)) begin
         disc_d = disc_q - ONE;
      end
   end

`ifdef CPU7_IFU_IMEM_RESP_BUF_EN
   logic             r_v, r_ex, r_unc;
   logic [GRLEN-1:0] r_rd;
   logic [5:0]       r_code;

   // ADEF is loaded at acceptance so it lands one cycle later, like the passthrough build
   always_comb begin
      resp_v    = bus_valid;
      resp_ex   = bus_err & bus_valid;
      resp_code = (bus_err & bus_valid) ? BUSERR_CODE : 6'h00;
      resp_rd   = GRLEN'(bus_rdata);
      resp_unc  = bus_uncache;
      if (adef_acc) begin
         resp_v    = 1'b1;
         resp_ex   = 1'b1;
         resp_code = ADEF_CODE;
         resp_rd   = '0;
         resp_unc  = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_v    <= 1'b0;
         r_ex   <= 1'b0;
         r_unc  <= 1'b0;
         r_rd   <= '0;
         r_code <= '0;
      end else begin
         r_v    <= resp_v;
         r_ex   <= resp_ex;
         r_unc  <= resp_unc;
         r_rd   <= resp_rd;
         r_code <= resp_code;
      end
   end

   // a redirect hides a buffered beat in the cycle it is raised
   always_comb begin
      out_v    = r_v & ~inst_cancel;
      out_ex   = r_ex & ~inst_cancel;
      out_code = (r_ex & ~inst_cancel) ? r_code : 6'h00;
      out_rd   = r_rd;
      out_unc  = r_unc;
   end
`else
   always_comb begin
      resp_v    = bus_valid;
      resp_ex   = bus_err & bus_valid;
      resp_code = (bus_err & bus_valid) ? BUSERR_CODE : 6'h00;
      resp_rd   = GRLEN'(bus_rdata);
      resp_unc  = bus_uncache;
      if (adef_pend_q) begin
         resp_v    = ~inst_cancel;
         resp_ex   = ~inst_cancel;
         resp_code = inst_cancel ? 6'h00 : ADEF_CODE;
         resp_rd   = '0;
         resp_unc  = 1'b0;
      end
   end

   always_comb begin
      out_v    = resp_v;
      out_ex   = resp_ex;
      out_code = resp_code;
      out_rd   = resp_rd;
      out_unc  = resp_unc;
   end
`endif

   // outputs held at reset values while reset is asserted
   always_comb begin
      inst_addr_ok = 1'b0;
      inst_valid_f = 1'b0;
      inst_rdata_f = '0;
      inst_ex      = 1'b0;
      inst_exccode = 6'h00;
      inst_count   = 2'd1;
      inst_uncache = 1'b0;
      bus_req      = 1'b0;
      bus_addr     = 32'h0;
      if (!reset) begin
         inst_addr_ok = acc | adef_acc;
         inst_valid_f = out_v;
         inst_rdata_f = out_rd;
         inst_ex      = out_ex;
         inst_exccode = out_code;
         inst_uncache = out_unc;
         bus_req      = issue;
         bus_addr     = inst_addr;
      end
   end

   a_no_spurious_data_ok: assert property (@(posedge clock) disable iff (reset)
      !(bus_data_ok && (outst_q == '0)));

endmodule
